// File: rtl/avalon_mem_responder.sv
// Avalon-MM responder backing an on-chip 32-bit word memory.
// Reads return after a fixed latency through a shift pipeline and are always
// in order; writes are byte-enabled and land at the end of the accept cycle.
// waitrequest is combinational so a stalled master sees it in the same cycle.
module avalon_mem_responder #(
    parameter int ADDR_WIDTH   = 26,
    parameter int WORD_BITS    = 12,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] slave_address,
    input  logic                  slave_read,
    input  logic                  slave_write,
    input  logic [3:0]            slave_byteenable,
    input  logic [31:0]           slave_writedata,
    output logic [31:0]           slave_readdata,
    output logic                  slave_readdatavalid,
    output logic                  slave_waitrequest,
    input  logic                  stall_inject,
    output logic                  protocol_error,
    output logic [15:0]           read_count,
    output logic [15:0]           write_count
);

    localparam int DEPTH = 1 << WORD_BITS;

    logic [31:0]          mem [DEPTH];
    logic [WORD_BITS-1:0] word_idx;
    logic [3:0]           pending;
    logic                 accept_rd;
    logic                 accept_wr;

    // Response pipeline: stage 0 is loaded at the end of the accept cycle,
    // so the last stage is visible exactly READ_LATENCY cycles after accept.
    // Data is forced to zero for empty slots so readdata idles at zero.
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [31:0]             pipe_data [READ_LATENCY];

    // Address bits outside the word index are ignored; the memory aliases.
    logic unused_addr;
    assign unused_addr = ^{slave_address[ADDR_WIDTH-1:WORD_BITS+2], slave_address[1:0]};

    assign word_idx = slave_address[WORD_BITS+1:2];

    // Writes are never throttled by the read pending count.
    assign slave_waitrequest = stall_inject
                             | (slave_read & slave_write)
                             | (slave_read & (pending == 4'(MAX_PENDING)));

    assign accept_rd = slave_read  & ~slave_write & ~slave_waitrequest;
    assign accept_wr = slave_write & ~slave_read  & ~slave_waitrequest;

    assign slave_readdatavalid = pipe_vld[READ_LATENCY-1];
    assign slave_readdata      = pipe_data[READ_LATENCY-1];

    // Byte-enabled memory write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (accept_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (slave_byteenable[b]) begin
                    mem[word_idx][8*b +: 8] <= slave_writedata[8*b +: 8];
                end
            end
        end
    end

    // Read response pipeline; reset drops every in-flight read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= accept_rd;
            pipe_data[0] <= accept_rd ? mem[word_idx] : 32'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // Outstanding-read count: up on accept, down on the returning pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            case ({accept_rd, slave_readdatavalid})
                2'b10:   pending <= pending + 4'd1;
                2'b01:   pending <= pending - 4'd1;
                default: pending <= pending;
            endcase
        end
    end

    // Transfer counters (wrap silently) and sticky read+write collision flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_count     <= '0;
            write_count    <= '0;
            protocol_error <= 1'b0;
        end else begin
            if (accept_rd) read_count  <= read_count + 16'd1;
            if (accept_wr) write_count <= write_count + 16'd1;
            if (slave_read & slave_write) protocol_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Bench for avalon_mem_responder: directed scenarios plus randomized traffic
// checked against a word-array model and an expected-response queue.
module tb_avalon_mem_responder;

    localparam int L   = 3;
    localparam int MAX = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [25:0] addr;
    logic        rd, wr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        rvalid, wait_req;
    logic        stall;
    logic        perr;
    logic [15:0] rcnt, wcnt;

    logic [25:0] addr6;
    logic        rd6;
    logic [31:0] rdata6;
    logic        rvalid6, wait6, perr6;
    logic [15:0] rcnt6, wcnt6;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic [31:0] model_mem [int];
    exp_t        exp_q [$];
    int          due_q [$];
    int          exp_rc = 0;
    int          exp_wc = 0;
    logic [31:0] last_rdata;
    int          v6_cnt = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    avalon_mem_responder #(.ADDR_WIDTH(26), .WORD_BITS(12), .READ_LATENCY(L), .MAX_PENDING(MAX)) dut (
        .clock(clock), .reset(reset),
        .slave_address(addr), .slave_read(rd), .slave_write(wr),
        .slave_byteenable(be), .slave_writedata(wd),
        .slave_readdata(rdata), .slave_readdatavalid(rvalid), .slave_waitrequest(wait_req),
        .stall_inject(stall), .protocol_error(perr),
        .read_count(rcnt), .write_count(wcnt)
    );

    avalon_mem_responder #(.ADDR_WIDTH(26), .WORD_BITS(12), .READ_LATENCY(6), .MAX_PENDING(4)) dut6 (
        .clock(clock), .reset(reset),
        .slave_address(addr6), .slave_read(rd6), .slave_write(1'b0),
        .slave_byteenable(4'hF), .slave_writedata(32'd0),
        .slave_readdata(rdata6), .slave_readdatavalid(rvalid6), .slave_waitrequest(wait6),
        .stall_inject(1'b0), .protocol_error(perr6),
        .read_count(rcnt6), .write_count(wcnt6)
    );

    // Response monitor: every pulse must match the queue head at its due cycle.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            due_q.delete();
        end else if (rvalid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rvalid cycle=%0d data=%h", cyc, rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                last_rdata = rdata;
                if (rdata !== e.data || cyc !== e.due) begin
                    fails++;
                    $display("FAIL read_response got data=%h cycle=%0d, want data=%h cycle=%0d",
                             rdata, cyc, e.data, e.due);
                end
            end
        end else begin
            tests++;
            if (rdata !== 32'd0) begin
                fails++;
                $display("FAIL idle_readdata got %h want 0", rdata);
            end
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                fails++;
                $display("FAIL missing_rvalid got none at cycle %0d want data=%h", cyc, e.data);
            end
        end
    end

    always @(negedge clock) if (!reset && rvalid6) v6_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic int pend_now();
        int n = 0;
        foreach (due_q[i]) if (due_q[i] >= cyc) n++;
        return n;
    endfunction

    // One transfer; leaves the request asserted so calls can run back to back.
    task automatic xfer(input bit is_wr, input logic [25:0] a, input logic [3:0] bev, input logic [31:0] d);
        int          waits = 0;
        bit          exp_wait;
        int          idx;
        logic [31:0] w;
        addr = a; rd = !is_wr; wr = is_wr; be = bev; wd = d;
        idx = int'(a[13:2]);
        forever begin
            @(negedge clock);
            exp_wait = stall | (!is_wr && pend_now() >= MAX);
            tests++;
            if (wait_req !== exp_wait) begin
                fails++;
                $display("FAIL waitrequest got %b want %b (addr=%h wr=%b)", wait_req, exp_wait, a, is_wr);
            end
            if (!wait_req) begin
                if (is_wr) begin
                    w = model_mem.exists(idx) ? model_mem[idx] : 32'hxxxxxxxx;
                    for (int b = 0; b < 4; b++) if (bev[b]) w[8*b +: 8] = d[8*b +: 8];
                    model_mem[idx] = w;
                    exp_wc++;
                end else begin
                    exp_q.push_back('{model_mem[idx], cyc + L});
                    due_q.push_back(cyc + L);
                    exp_rc++;
                end
                @(posedge clock); #1;
                break;
            end
            waits++;
            if (waits > 40) begin
                tests++; fails++;
                $display("FAIL accept_timeout got no accept want accept (addr=%h)", a);
                @(posedge clock); #1;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic idle(input int n);
        rd = 1'b0; wr = 1'b0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic drain();
        int k = 0;
        rd = 1'b0; wr = 1'b0;
        while (exp_q.size() > 0 && k < 20) begin @(posedge clock); #1; k++; end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d outstanding want 0", exp_q.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic check_counts(input string tag);
        tests++;
        if (rcnt !== 16'(exp_rc) || wcnt !== 16'(exp_wc)) begin
            fails++;
            $display("FAIL %s_counts got rd=%0d wr=%0d want rd=%0d wr=%0d", tag, rcnt, wcnt, exp_rc, exp_wc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rd = 0; wr = 0; be = 0; wd = 0; addr = 0; stall = 0; rd6 = 0; addr6 = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests++;
        if (rvalid !== 1'b0 || rdata !== 32'd0 || perr !== 1'b0 || rcnt !== 16'd0 ||
            wcnt !== 16'd0 || wait_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got rv=%b rd=%h pe=%b rc=%0d wc=%0d wr=%b want all zero",
                     rvalid, rdata, perr, rcnt, wcnt, wait_req);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        xfer(1, 26'h40, 4'hF, 32'hDEADBEEF);
        xfer(0, 26'h40, 4'hF, 32'd0);
        drain();
        tests++;
        if (last_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL basic_read got %h want deadbeef", last_rdata);
        end
        check_counts("basic");
    endtask

    task automatic test_byteenable();
        xfer(1, 26'h80, 4'hF, 32'hAABBCCDD);
        xfer(1, 26'h80, 4'b0101, 32'h11223344);
        xfer(0, 26'h80, 4'hF, 32'd0);
        drain();
        tests++;
        if (last_rdata !== 32'hAA22CC44) begin
            fails++;
            $display("FAIL byteenable_merge got %h want aa22cc44", last_rdata);
        end
        xfer(1, 26'h80, 4'b0000, 32'hFFFFFFFF);
        xfer(0, 26'h80, 4'hF, 32'd0);
        drain();
        tests++;
        if (last_rdata !== 32'hAA22CC44) begin
            fails++;
            $display("FAIL byteenable_zero got %h want aa22cc44", last_rdata);
        end
        check_counts("byteenable");
    endtask

    task automatic test_back_to_back();
        xfer(0, 26'h40, 4'hF, 0);
        xfer(0, 26'h80, 4'hF, 0);
        xfer(0, 26'h40, 4'hF, 0);
        xfer(0, 26'h80, 4'hF, 0);
        xfer(0, 26'h40, 4'hF, 0);
        xfer(0, 26'h80, 4'hF, 0);
        drain();
        check_counts("back_to_back");
    endtask

    task automatic test_latency6();
        int acc [$];
        int want [6] = '{0, 1, 2, 3, 7, 8};
        int k = 0;
        v6_cnt = 0;
        rd6 = 1'b1; addr6 = 26'h100;
        while (acc.size() < 6 && k < 40) begin
            @(negedge clock);
            if (!wait6) acc.push_back(cyc);
            @(posedge clock); #1;
            k++;
        end
        rd6 = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        tests++;
        if (acc.size() != 6) begin
            fails++;
            $display("FAIL lat6_accepts got %0d want 6", acc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (acc[i] - acc[0] !== want[i]) begin
                    fails++;
                    $display("FAIL lat6_accept_cycle[%0d] got +%0d want +%0d", i, acc[i] - acc[0], want[i]);
                end
            end
        end
        tests++;
        if (v6_cnt !== 6 || rcnt6 !== 16'd6) begin
            fails++;
            $display("FAIL lat6_responses got pulses=%0d count=%0d want 6/6", v6_cnt, rcnt6);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        addr = 26'hC0; wr = 1'b1; rd = 1'b0; be = 4'hF; wd = 32'h12345678;
        repeat (5) begin
            @(negedge clock);
            tests++;
            if (wait_req !== 1'b1) begin
                fails++;
                $display("FAIL stall_wait got %b want 1", wait_req);
            end
            @(posedge clock); #1;
        end
        check_counts("stall_hold");
        stall = 1'b0;
        xfer(1, 26'hC0, 4'hF, 32'h12345678);
        idle(1);
        check_counts("stall_release");
        xfer(0, 26'hC0, 4'hF, 0);
        drain();
    endtask

    task automatic test_protocol();
        addr = 26'h40; rd = 1'b1; wr = 1'b1; be = 4'hF; wd = 32'h0BADF00D;
        @(negedge clock);
        tests++;
        if (wait_req !== 1'b1) begin
            fails++;
            $display("FAIL protocol_wait got %b want 1", wait_req);
        end
        @(posedge clock); #1;
        idle(1);
        tests++;
        if (perr !== 1'b1) begin
            fails++;
            $display("FAIL protocol_error got %b want 1", perr);
        end
        check_counts("protocol");
        idle(4);
        tests++;
        if (perr !== 1'b1) begin
            fails++;
            $display("FAIL protocol_sticky got %b want 1", perr);
        end
        xfer(0, 26'h40, 4'hF, 0);
        drain();
        tests++;
        if (last_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL protocol_no_write got %h want deadbeef", last_rdata);
        end
    endtask

    task automatic test_random();
        logic [11:0] wi;
        logic [25:0] a;
        for (int i = 0; i < 16; i++) begin
            wi = 12'(256 + i);
            xfer(1, {12'($urandom), wi, 2'($urandom)}, 4'hF, $urandom);
        end
        for (int n = 0; n < 80; n++) begin
            wi = 12'(256 + $urandom_range(0, 15));
            a  = {12'($urandom), wi, 2'($urandom)};
            if ($urandom_range(0, 1) == 1) xfer(1, a, 4'($urandom), $urandom);
            else                           xfer(0, a, 4'hF, 32'd0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        check_counts("random");
    endtask

    task automatic test_reset_midflight();
        xfer(0, 26'h40, 4'hF, 0);
        xfer(0, 26'h80, 4'hF, 0);
        xfer(0, 26'hC0, 4'hF, 0);
        rd = 1'b0;
        reset = 1'b1;
        exp_rc = 0; exp_wc = 0;
        @(negedge clock);
        tests++;
        if (rvalid !== 1'b0 || rdata !== 32'd0 || perr !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state got rv=%b rd=%h pe=%b want 0/0/0", rvalid, rdata, perr);
        end
        check_counts("midreset");
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        idle(10);
        xfer(0, 26'h40, 4'hF, 0);
        drain();
        tests++;
        if (last_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL retained_data got %h want deadbeef", last_rdata);
        end
        xfer(0, 26'h4040, 4'hF, 0);
        drain();
        tests++;
        if (last_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL alias_read got %h want deadbeef", last_rdata);
        end
        check_counts("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byteenable();
        test_back_to_back();
        test_latency6();
        test_stall();
        test_protocol();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
